// File: rtl/param_reg_file.sv
// rtl/param_reg_file.sv - parametrised masked register file with inc/dec, shifts and sticky wrap flag
module param_reg_file #(
    parameter int                 NUM_REGS    = 4,
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter int                 SEL_W       = $clog2(NUM_REGS)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [WIDTH-1:0]      I,
    input  logic [2:0]            FunSel,
    input  logic [NUM_REGS-1:0]   RSel,
    input  logic [SEL_W-1:0]      O1Sel,
    input  logic [SEL_W-1:0]      O2Sel,
    output logic [WIDTH-1:0]      O1,
    output logic [WIDTH-1:0]      O2,
    output logic                  Wrap
);

    localparam int H         = WIDTH / 2;
    localparam int NUM_SLOTS = 1 << SEL_W;

    localparam logic [2:0] FS_CLEAR   = 3'b000;
    localparam logic [2:0] FS_LOAD    = 3'b001;
    localparam logic [2:0] FS_LOAD_LO = 3'b010;
    localparam logic [2:0] FS_LOAD_HI = 3'b011;
    localparam logic [2:0] FS_DEC     = 3'b100;
    localparam logic [2:0] FS_INC     = 3'b101;
    localparam logic [2:0] FS_SHL     = 3'b110;
    localparam logic [2:0] FS_SHR     = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wrap_hit;
    logic                wrap_q;
    logic                wrap_d;
    logic [WIDTH-1:0]    rd_slots [NUM_SLOTS];

    // Each register computes its own next value; wrap_hit[k] flags an overflow or lost bit.
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k]   = regs_q[k];
            wrap_hit[k] = 1'b0;
            if (RSel[k]) begin
                case (FunSel)
                    FS_CLEAR:   regs_d[k] = '0;
                    FS_LOAD:    regs_d[k] = I;
                    FS_LOAD_LO: regs_d[k] = {regs_q[k][WIDTH-1:H], I[H-1:0]};
                    FS_LOAD_HI: regs_d[k] = {I[H-1:0], regs_q[k][H-1:0]};
                    FS_DEC: begin
                        regs_d[k]   = regs_q[k] - ONE;
                        wrap_hit[k] = (regs_q[k] == '0);
                    end
                    FS_INC: begin
                        regs_d[k]   = regs_q[k] + ONE;
                        wrap_hit[k] = &regs_q[k];
                    end
                    FS_SHL: begin
                        regs_d[k]   = {regs_q[k][WIDTH-2:0], 1'b0};
                        wrap_hit[k] = regs_q[k][WIDTH-1];
                    end
                    FS_SHR: begin
                        regs_d[k]   = {1'b0, regs_q[k][WIDTH-1:1]};
                        wrap_hit[k] = regs_q[k][0];
                    end
                    default: regs_d[k] = regs_q[k];
                endcase
            end
        end
    end

    always_comb begin
        wrap_d = wrap_q;
        if ((FunSel == FS_CLEAR) && (|RSel)) begin
            wrap_d = 1'b0;
        end else if (|wrap_hit) begin
            wrap_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VALUE;
            end
            wrap_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            wrap_q <= wrap_d;
        end
    end

    // Pad the read space to a power of two so unused indices return zero.
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_rd
        if (s < NUM_REGS) begin : g_used
            assign rd_slots[s] = regs_q[s];
        end else begin : g_empty
            assign rd_slots[s] = '0;
        end
    end

    assign O1   = rd_slots[O1Sel];
    assign O2   = rd_slots[O2Sel];
    assign Wrap = wrap_q;

endmodule

// File: tb/tb_param_reg_file.sv
// tb/tb_param_reg_file.sv - self-checking bench for param_reg_file against an arithmetic model
module tb_param_reg_file;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int M  = 1 << W;
    localparam int HM = 1 << (W / 2);

    logic         Clock;
    logic         Reset;
    logic [W-1:0] I;
    logic [2:0]   FunSel;
    logic [NR-1:0] RSel;
    logic [1:0]   O1Sel;
    logic [1:0]   O2Sel;
    logic [W-1:0] O1;
    logic [W-1:0] O2;
    logic         Wrap;

    int checks;
    int failures;
    bit check_en;
    int mregs [NR];
    bit mwrap;

    param_reg_file #(
        .NUM_REGS(NR),
        .WIDTH(W),
        .RESET_VALUE(8'h00)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .I(I),
        .FunSel(FunSel),
        .RSel(RSel),
        .O1Sel(O1Sel),
        .O2Sel(O2Sel),
        .O1(O1),
        .O2(O2),
        .Wrap(Wrap)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mread(input int idx);
        return (idx < NR) ? mregs[idx] : 0;
    endfunction

    task automatic model_update();
        bit hit;
        int r;
        int d;
        hit = 1'b0;
        d = int'(I);
        if (Reset) begin
            for (int k = 0; k < NR; k++) mregs[k] = 0;
            mwrap = 1'b0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (RSel[k]) begin
                    r = mregs[k];
                    case (FunSel)
                        3'd0: mregs[k] = 0;
                        3'd1: mregs[k] = d;
                        3'd2: mregs[k] = r - (r % HM) + (d % HM);
                        3'd3: mregs[k] = (d % HM) * HM + (r % HM);
                        3'd4: begin mregs[k] = (r + M - 1) % M; if (r == 0) hit = 1'b1; end
                        3'd5: begin mregs[k] = (r + 1) % M; if (r == M - 1) hit = 1'b1; end
                        3'd6: begin mregs[k] = (r * 2) % M; if (r >= M / 2) hit = 1'b1; end
                        default: begin mregs[k] = r / 2; if (r % 2 == 1) hit = 1'b1; end
                    endcase
                end
            end
            if (FunSel == 3'd0 && RSel != '0) mwrap = 1'b0;
            else if (hit) mwrap = 1'b1;
        end
    endtask

    task automatic drive(input bit r, input logic [2:0] fs, input logic [NR-1:0] rs,
                         input logic [W-1:0] d, input logic [1:0] s1, input logic [1:0] s2);
        Reset  = r;
        FunSel = fs;
        RSel   = rs;
        I      = d;
        O1Sel  = s1;
        O2Sel  = s2;
    endtask

    task automatic clk_edge();
        @(posedge Clock);
        model_update();
        #1;
    endtask

    task automatic step(input bit r, input logic [2:0] fs, input logic [NR-1:0] rs,
                        input logic [W-1:0] d, input logic [1:0] s1, input logic [1:0] s2);
        drive(r, fs, rs, d, s1, s2);
        clk_edge();
    endtask

    always @(negedge Clock) begin
        if (check_en) begin
            chk("model_o1", int'(O1), mread(int'(O1Sel)));
            chk("model_o2", int'(O2), mread(int'(O2Sel)));
            chk("model_wrap", int'(Wrap), int'(mwrap));
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        check_en = 1'b0;
        mwrap = 1'b0;
        for (int k = 0; k < NR; k++) mregs[k] = 0;
        drive(1'b1, 3'd0, 4'b0000, 8'h00, 2'd0, 2'd0);
        @(negedge Clock);
        clk_edge();
        check_en = 1'b1;
        chk("reset_o1", int'(O1), 0);
        chk("reset_wrap", int'(Wrap), 0);

        step(1'b0, 3'b001, 4'b0101, 8'h5A, 2'd0, 2'd2);
        chk("t1_r0", int'(O1), 'h5A);
        chk("t1_r2", int'(O2), 'h5A);
        chk("t1_wrap", int'(Wrap), 0);
        step(1'b0, 3'b001, 4'b0000, 8'hFF, 2'd1, 2'd3);
        chk("t1_r1", int'(O1), 'h00);

        step(1'b0, 3'b010, 4'b0010, 8'h0C, 2'd1, 2'd1);
        chk("t2_lo", int'(O1), 'h0C);
        step(1'b0, 3'b011, 4'b0010, 8'h0A, 2'd1, 2'd1);
        chk("t2_hi", int'(O1), 'hAC);

        step(1'b0, 3'b100, 4'b1000, 8'h00, 2'd3, 2'd3);
        chk("t3_dec", int'(O1), 'hFF);
        chk("t3_dec_wrap", int'(Wrap), 1);
        step(1'b0, 3'b101, 4'b1000, 8'h00, 2'd3, 2'd3);
        chk("t3_inc", int'(O1), 'h00);
        chk("t3_inc_wrap", int'(Wrap), 1);
        step(1'b0, 3'b000, 4'b0001, 8'h00, 2'd3, 2'd3);
        chk("t3_clr_wrap", int'(Wrap), 0);

        step(1'b0, 3'b001, 4'b0001, 8'h81, 2'd0, 2'd0);
        step(1'b0, 3'b110, 4'b0001, 8'h00, 2'd0, 2'd0);
        chk("t4_shl", int'(O1), 'h02);
        chk("t4_shl_wrap", int'(Wrap), 1);
        step(1'b0, 3'b000, 4'b0010, 8'h00, 2'd0, 2'd0);
        chk("t4_clr_wrap", int'(Wrap), 0);
        step(1'b0, 3'b111, 4'b0001, 8'h00, 2'd0, 2'd0);
        chk("t4_shr1", int'(O1), 'h01);
        chk("t4_shr1_wrap", int'(Wrap), 0);
        step(1'b0, 3'b111, 4'b0001, 8'h00, 2'd0, 2'd0);
        chk("t4_shr2", int'(O1), 'h00);
        chk("t4_shr2_wrap", int'(Wrap), 1);

        step(1'b0, 3'b001, 4'b1111, 8'h33, 2'd0, 2'd1);
        chk("t5_load", int'(O2), 'h33);
        step(1'b1, 3'b101, 4'b1111, 8'h00, 2'd0, 2'd1);
        chk("t5_r0", int'(O1), 0);
        chk("t5_r1", int'(O2), 0);
        chk("t5_wrap", int'(Wrap), 0);
        step(1'b0, 3'b101, 4'b0000, 8'h00, 2'd2, 2'd3);
        chk("t5_r2", int'(O1), 0);
        chk("t5_r3", int'(O2), 0);

        drive(1'b0, 3'b001, 4'b0100, 8'h77, 2'd2, 2'd2);
        #1;
        chk("t6_before", int'(O1), 'h00);
        clk_edge();
        chk("t6_after", int'(O1), 'h77);
        step(1'b0, 3'b101, 4'b0000, 8'h00, 2'd2, 2'd2);
        chk("t6_noop", int'(O1), 'h77);
        chk("t6_noop_wrap", int'(Wrap), 0);

        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 49) == 0),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)));
        end

        @(negedge Clock);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
